// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel coordinates and lock status from a raw
// hsync/vsync/blank_b timing stream. Inputs are registered once, outputs once
// (2 clk input-to-output latency).
// Optional build macro VGA_SYNC_DECODER_STATS_EN adds frame_count/err_count.
module vga_sync_decoder #(
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned V_TOTAL  = 525,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       blank_b,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       pixel_valid,
  output logic       locked,
  output logic       frame_start,
  output logic       sync_err
`ifdef VGA_SYNC_DECODER_STATS_EN
  ,
  output logic [15:0] frame_count,
  output logic [7:0]  err_count
`endif
);

  localparam logic [11:0] H_TOT = 12'(H_TOTAL);
  localparam logic [11:0] V_TOT = 12'(V_TOTAL);
  localparam logic [11:0] H_ACT = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT = 12'(V_ACTIVE);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    HLOCK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t      state, state_n;

  logic        hs_r, vs_r, bl_r;
  logic        hs_p, vs_p;
  logic [10:0] hcnt, hcnt_n;
  logic [10:0] vcnt, vcnt_n;
  logic        vpend, vpend_n;
  logic        match_seen, match_n;
  logic        fb_seen, fbs_n;
  logic [9:0]  xcnt, xcnt_n, x_cur;
  logic [9:0]  ycnt, y_cur;
  logic        line_vis, line_vis_n;

  logic        line_start, v_fall, frame_bound;
  logic        len_ok, frame_ok, h_sat, h_over, v_over;
  logic        err_n, fs_n, lock_n;

  // Event detection and counter next-values from the registered inputs
  always_comb begin
    line_start  = hs_p & ~hs_r;
    v_fall      = vs_p & ~vs_r;
    frame_bound = line_start & (vpend | v_fall);

    len_ok   = (({1'b0, hcnt} + 12'd1) == H_TOT);
    frame_ok = (({1'b0, vcnt} + 12'd1) == V_TOT);
    h_sat    = !line_start && (hcnt == '1);

    hcnt_n = line_start ? '0 : ((hcnt == '1) ? hcnt : hcnt + 11'd1);

    vcnt_n = vcnt;
    if (frame_bound)
      vcnt_n = '0;
    else if (line_start && vcnt != '1)
      vcnt_n = vcnt + 11'd1;

    vpend_n = vpend;
    if (frame_bound)
      vpend_n = 1'b0;
    else if (v_fall)
      vpend_n = 1'b1;

    // x shown for this cycle is the pixel count before this cycle's pixel
    x_cur  = line_start ? '0 : xcnt;
    xcnt_n = (bl_r && x_cur != '1) ? x_cur + 10'd1 : x_cur;
    h_over = bl_r && ({2'b00, x_cur} >= H_ACT);

    line_vis_n = line_start ? bl_r : (line_vis | bl_r);

    // y advances when the line that just ended carried visible pixels
    y_cur = ycnt;
    if (frame_bound)
      y_cur = '0;
    else if (line_start && line_vis && ycnt != '1)
      y_cur = ycnt + 10'd1;
    v_over = line_start && line_vis && ({2'b00, ycnt} >= V_ACT);
  end

  // Lock state machine: next state, match/boundary tracking, error pulse
  always_comb begin
    state_n = state;
    match_n = match_seen;
    fbs_n   = fb_seen;
    err_n   = 1'b0;
    case (state)
      SEARCH: begin
        fbs_n = 1'b0;
        if (line_start) begin
          if (len_ok) begin
            if (match_seen) begin
              state_n = HLOCK;
              match_n = 1'b0;
            end else begin
              match_n = 1'b1;
            end
          end else begin
            match_n = 1'b0;
          end
        end
      end
      HLOCK: begin
        match_n = 1'b0;
        if (line_start && !len_ok) begin
          state_n = SEARCH;
          fbs_n   = 1'b0;
        end else if (frame_bound) begin
          if (fb_seen) begin
            fbs_n   = 1'b0;
            state_n = frame_ok ? LOCKED : SEARCH;
          end else begin
            fbs_n = 1'b1;
          end
        end
      end
      LOCKED: begin
        match_n = 1'b0;
        fbs_n   = 1'b0;
        if ((line_start && !len_ok) || (frame_bound && !frame_ok) ||
            h_sat || h_over || v_over) begin
          state_n = SEARCH;
          err_n   = 1'b1;
        end
      end
      default: begin
        state_n = SEARCH;
        match_n = 1'b0;
        fbs_n   = 1'b0;
      end
    endcase
    lock_n = (state_n == LOCKED);
    fs_n   = frame_bound && lock_n;
  end

  // Input registers, timing counters, state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_r        <= 1'b1;
      vs_r        <= 1'b1;
      bl_r        <= 1'b0;
      hs_p        <= 1'b1;
      vs_p        <= 1'b1;
      hcnt        <= '0;
      vcnt        <= '0;
      vpend       <= 1'b0;
      match_seen  <= 1'b0;
      fb_seen     <= 1'b0;
      xcnt        <= '0;
      ycnt        <= '0;
      line_vis    <= 1'b0;
      state       <= SEARCH;
      x           <= '0;
      y           <= '0;
      pixel_valid <= 1'b0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      hs_r        <= hsync;
      vs_r        <= vsync;
      bl_r        <= blank_b;
      hs_p        <= hs_r;
      vs_p        <= vs_r;
      hcnt        <= hcnt_n;
      vcnt        <= vcnt_n;
      vpend       <= vpend_n;
      match_seen  <= match_n;
      fb_seen     <= fbs_n;
      xcnt        <= xcnt_n;
      ycnt        <= y_cur;
      line_vis    <= line_vis_n;
      state       <= state_n;
      x           <= lock_n ? x_cur : '0;
      y           <= lock_n ? y_cur : '0;
      pixel_valid <= lock_n & bl_r;
      locked      <= lock_n;
      frame_start <= fs_n;
      sync_err    <= err_n;
    end
  end

`ifdef VGA_SYNC_DECODER_STATS_EN
  // Frame counter wraps, error counter saturates
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_count <= '0;
      err_count   <= '0;
    end else begin
      if (fs_n)
        frame_count <= frame_count + 16'd1;
      if (err_n && err_count != '1)
        err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule
